elevator_floor_controller: RTL and testbench

- Sequential stage directly downstream of floor_position_detector.
- Consumes the encoded current_floor plus a sensor-valid flag.
- Accepts floor requests and holds them in a pending bitmap.
- Drives the motor up/down commands and the door-open output using a single-car SCAN policy (keep direction while requests lie ahead).

---
 rtl/elevator_floor_controller.sv | 188 ++++++++++++++++++
 tb/tb_elevator_floor_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_floor_controller.sv
// Single-car SCAN floor controller fed by floor_position_detector; holds a pending request bitmap.
// Define FLOOR_TIMEOUT_EN to add the move watchdog that latches FAULT when the car stops reporting progress.
module elevator_floor_controller #(
    parameter int NUM_FLOORS     = 10,
    parameter int FLOOR_WIDTH    = 4,
    parameter int DOOR_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FLOOR_WIDTH-1:0] current_floor,
    input  logic                   floor_valid,
    input  logic                   req_valid,
    input  logic [FLOOR_WIDTH-1:0] req_floor,
    output logic                   req_ready,
    output logic                   req_err,
    output logic [NUM_FLOORS-1:0]  pending,
    output logic                   motor_up,
    output logic                   motor_down,
    output logic                   door_open,
    output logic                   arrived,
    output logic                   fault
);
    localparam int DCW = $clog2(DOOR_CYCLES + 1);
    localparam logic [DCW-1:0]         DOOR_LAST = DCW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR = FLOOR_WIDTH'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR, FAULT} state_t;

    state_t                 state_reg;
    logic [NUM_FLOORS-1:0]  pending_reg;
    logic [NUM_FLOORS-1:0]  pending_next;
    logic [NUM_FLOORS-1:0]  set_mask;
    logic [NUM_FLOORS-1:0]  clr_mask;
    logic [FLOOR_WIDTH-1:0] pos_reg;
    logic [FLOOR_WIDTH-1:0] here;
    logic                   dir_up_reg;
    logic [DCW-1:0]         door_cnt_reg;

    logic [NUM_FLOORS-1:0]  pos_hot, cur_hot, req_hot;
    logic [NUM_FLOORS-1:0]  above_pos, below_pos, above_here, below_here;
    logic accept, door_restart, idle_stop, cur_hit;
    logic wants_up, wants_down, ahead_up, ahead_down, move_exit, wd_expire;

    assign accept  = req_valid && req_ready;
    // While between floors the last latched floor stands in for the car position.
    assign here    = floor_valid ? current_floor : pos_reg;
    assign pending = pending_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi = gi + 1) begin : g_floor
            localparam logic [FLOOR_WIDTH-1:0] FI = FLOOR_WIDTH'(gi);
            assign pos_hot[gi]    = (pos_reg == FI);
            assign cur_hot[gi]    = (current_floor == FI);
            assign req_hot[gi]    = accept && (req_floor == FI);
            assign above_pos[gi]  = (FI > pos_reg);
            assign below_pos[gi]  = (FI < pos_reg);
            assign above_here[gi] = (FI > here);
            assign below_here[gi] = (FI < here);
        end
    endgenerate

    assign door_restart = (state_reg == DOOR) && accept && (req_floor == pos_reg);
    assign idle_stop    = |(pending_reg & pos_hot);
    assign wants_up     = |(pending_reg & above_pos);
    assign wants_down   = |(pending_reg & below_pos);
    assign ahead_up     = |(pending_reg & above_here);
    assign ahead_down   = |(pending_reg & below_here);
    // A request landing on the floor the car is passing stops it there (arrival wins).
    assign cur_hit      = floor_valid && |((pending_reg | req_hot) & cur_hot);
    assign move_exit    = ((state_reg == MOVE_UP)   && ((here == TOP_FLOOR) || !ahead_up)) ||
                          ((state_reg == MOVE_DOWN) && ((here == '0) || !ahead_down));

    always_comb begin
        set_mask = door_restart ? '0 : req_hot;
        clr_mask = '0;
        if (state_reg == IDLE && idle_stop)
            clr_mask = pos_hot;
        else if ((state_reg == MOVE_UP || state_reg == MOVE_DOWN) && cur_hit)
            clr_mask = cur_hot;
        pending_next = (pending_reg | set_mask) & ~clr_mask;
    end

`ifdef FLOOR_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt_reg;
    logic           in_move, pos_change;

    assign in_move    = (state_reg == MOVE_UP) || (state_reg == MOVE_DOWN);
    assign pos_change = floor_valid && (current_floor != pos_reg);
    assign wd_expire  = in_move && !pos_change && !cur_hit && !move_exit &&
                        (wd_cnt_reg == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt_reg <= '0;
        else if (!in_move || pos_change)
            wd_cnt_reg <= '0;
        else
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault <= 1'b0;
        else if (wd_expire)
            fault <= 1'b1;
    end
`else
    assign wd_expire = 1'b0;
    assign fault     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            pos_reg      <= '0;
            dir_up_reg   <= 1'b1;
            door_cnt_reg <= '0;
            req_ready    <= 1'b0;
            req_err      <= 1'b0;
            motor_up     <= 1'b0;
            motor_down   <= 1'b0;
            door_open    <= 1'b0;
            arrived      <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (floor_valid)
                pos_reg <= current_floor;
            req_ready  <= 1'b1;
            req_err    <= accept && !(|req_hot);
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
            arrived    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (idle_stop) begin
                        state_reg    <= DOOR;
                        door_cnt_reg <= DOOR_LAST;
                        door_open    <= 1'b1;
                    end else if (wants_up && (dir_up_reg || !wants_down)) begin
                        state_reg  <= MOVE_UP;
                        dir_up_reg <= 1'b1;
                        motor_up   <= 1'b1;
                    end else if (wants_down) begin
                        state_reg  <= MOVE_DOWN;
                        dir_up_reg <= 1'b0;
                        motor_down <= 1'b1;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (cur_hit) begin
                        state_reg    <= DOOR;
                        door_cnt_reg <= DOOR_LAST;
                        door_open    <= 1'b1;
                        arrived      <= 1'b1;
                    end else if (move_exit) begin
                        state_reg <= IDLE;
                    end else if (wd_expire) begin
                        state_reg <= FAULT;
                        req_ready <= 1'b0;
                    end else begin
                        motor_up   <= (state_reg == MOVE_UP);
                        motor_down <= (state_reg == MOVE_DOWN);
                    end
                end
                DOOR: begin
                    door_open <= 1'b1;
                    if (door_restart) begin
                        door_cnt_reg <= DOOR_LAST;
                    end else if (door_cnt_reg == '0) begin
                        state_reg <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        door_cnt_reg <= door_cnt_reg - 1'b1;
                    end
                end
                FAULT: begin
                    req_ready <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_floor_controller.sv
// Randomized bench for elevator_floor_controller: a simple car plant drives the sensors and a
// behavioural request/stop model predicts every output each cycle.
module tb_elevator_floor_controller;
    localparam int NF = 10;
    localparam int FW = 4;
    localparam int DC = 4;
    localparam int TO = 20;

    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;
    localparam int M_DOOR  = 3;
    localparam int M_FAULT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] current_floor;
    logic          floor_valid;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic          req_ready;
    logic          req_err;
    logic [NF-1:0] pending;
    logic          motor_up;
    logic          motor_down;
    logic          door_open;
    logic          arrived;
    logic          fault;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_pend[NF];
    int m_mode;
    int m_pos;
    bit m_dir_up;
    int m_door_left;
    int m_wd;
    bit e_arr, e_err, e_ready;

    // Car plant: position in quarter-floor steps
    int loc = 0;
    bit stall = 1'b0;

    always #5 clk = ~clk;

    elevator_floor_controller #(
        .NUM_FLOORS(NF), .FLOOR_WIDTH(FW), .DOOR_CYCLES(DC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .current_floor(current_floor), .floor_valid(floor_valid),
        .req_valid(req_valid), .req_floor(req_floor),
        .req_ready(req_ready), .req_err(req_err), .pending(pending),
        .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
        .arrived(arrived), .fault(fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit any_pending(input int lo, input int hi);
        for (int f = lo; f <= hi; f++)
            if (f >= 0 && f < NF && m_pend[f]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] pend_vec();
        logic [NF-1:0] v;
        for (int f = 0; f < NF; f++) v[f] = m_pend[f];
        return v;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
        m_mode = M_IDLE; m_pos = 0; m_dir_up = 1'b1; m_door_left = 0; m_wd = 0;
        e_arr = 1'b0; e_err = 1'b0; e_ready = 1'b0;
    endtask

    task automatic model_step();
        bit accept, ok, hit, up, dn, going_up, no_ahead;
        int rf, cf, here, old_pos, set_f, clr_f;
        accept  = req_valid && e_ready;
        rf      = int'(req_floor);
        cf      = int'(current_floor);
        ok      = accept && rf < NF;
        old_pos = m_pos;
        here    = floor_valid ? cf : old_pos;
        e_err   = accept && !ok;
        e_arr   = 1'b0;
        set_f   = ok ? rf : -1;
        clr_f   = -1;
        if (accept) $display("request floor %0d accepted at t=%0t", rf, $time);
        case (m_mode)
            M_IDLE: begin
                m_wd = 0;
                if (m_pend[old_pos]) begin
                    m_mode = M_DOOR; m_door_left = DC; clr_f = old_pos;
                end else begin
                    up = any_pending(old_pos + 1, NF - 1);
                    dn = any_pending(0, old_pos - 1);
                    if (up && (m_dir_up || !dn)) begin m_mode = M_UP; m_dir_up = 1'b1; end
                    else if (dn) begin m_mode = M_DOWN; m_dir_up = 1'b0; end
                end
            end
            M_UP, M_DOWN: begin
                going_up = (m_mode == M_UP);
                hit = floor_valid && cf < NF && (m_pend[cf] || (ok && rf == cf));
                no_ahead = going_up ? (here == NF - 1 || !any_pending(here + 1, NF - 1))
                                    : (here == 0 || !any_pending(0, here - 1));
                if (hit) begin
                    m_mode = M_DOOR; m_door_left = DC; e_arr = 1'b1; clr_f = cf; m_wd = 0;
                end else if (no_ahead) begin
                    m_mode = M_IDLE; m_wd = 0;
                end else begin
`ifdef FLOOR_TIMEOUT_EN
                    if (floor_valid && cf != old_pos) m_wd = 0;
                    else if (m_wd == TO - 1) begin m_mode = M_FAULT; m_wd = 0; end
                    else m_wd++;
`endif
                end
            end
            M_DOOR: begin
                m_wd = 0;
                if (ok && rf == old_pos) begin m_door_left = DC; set_f = -1; end
                else if (m_door_left == 1) m_mode = M_IDLE;
                else m_door_left--;
            end
            default: ;
        endcase
        if (set_f >= 0) m_pend[set_f] = 1'b1;
        if (clr_f >= 0) m_pend[clr_f] = 1'b0;
        if (floor_valid) m_pos = cf;
        e_ready = (m_mode != M_FAULT);
    endtask

    task automatic compare_all();
        check_eq("pending",    pending,    pend_vec());
        check_eq("motor_up",   motor_up,   m_mode == M_UP);
        check_eq("motor_down", motor_down, m_mode == M_DOWN);
        check_eq("motor_excl", motor_up & motor_down, 0);
        check_eq("door_open",  door_open,  m_mode == M_DOOR);
        check_eq("arrived",    arrived,    e_arr);
        check_eq("req_err",    req_err,    e_err);
        check_eq("req_ready",  req_ready,  e_ready);
        check_eq("fault",      fault,      m_mode == M_FAULT);
    endtask

    task automatic drive_inputs(input int req_pct, input int force_floor);
        if (!stall) begin
            if (motor_up && loc < 4 * (NF - 1)) loc++;
            else if (motor_down && loc > 0) loc--;
        end
        floor_valid   = !stall && (loc % 4 == 0);
        current_floor = floor_valid ? FW'(loc / 4) : FW'($urandom_range(0, 15));
        if (force_floor >= 0) begin
            req_valid = 1'b1;
            req_floor = FW'(force_floor);
        end else begin
            req_valid = ($urandom_range(0, 99) < req_pct);
            if ($urandom_range(0, 3) == 0) req_floor = FW'((loc + 2) / 4);
            else req_floor = FW'($urandom_range(0, 11));
        end
    endtask

    task automatic run_cycles(input int n, input int req_pct, input int force_floor);
        for (int i = 0; i < n; i++) begin
            drive_inputs(req_pct, force_floor);
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic async_reset_mid_move();
        int waited = 0;
        while (!(motor_up || motor_down) && waited < 400) begin
            run_cycles(1, 30, -1);
            waited++;
        end
        check_eq("move_seen", motor_up | motor_down, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_motor_up",   motor_up,   0);
        check_eq("rst_motor_down", motor_down, 0);
        check_eq("rst_pending",    pending,    0);
        check_eq("rst_req_ready",  req_ready,  0);
        model_reset();
        req_valid = 1'b0;
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        run_cycles(6, 0, -1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_floor = '0;
        floor_valid = 1'b1;
        current_floor = '0;
        do_reset();

        run_cycles(3000, 15, -1);
        async_reset_mid_move();
        run_cycles(800, 25, -1);
        async_reset_mid_move();

`ifdef FLOOR_TIMEOUT_EN
        loc = 0;
        stall = 1'b0;
        do_reset();
        run_cycles(3, 0, -1);
        run_cycles(1, 0, 9);
        stall = 1'b1;
        run_cycles(TO + 10, 10, -1);
        check_eq("fault_set",   fault,     1);
        check_eq("fault_ready", req_ready, 0);
        check_eq("fault_motor", motor_up | motor_down, 0);
        stall = 1'b0;
        do_reset();
        run_cycles(50, 20, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end
endmodule
